test19_server1: RTL and testbench



---
 rtl/test19_server1.sv | 275 +++++++++++++++++++++++++++
 tb/tb_test19_server1.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/test19_server1.sv
// -----------------------------------------------------------------------------
// test19_server1
// RPC server with three entry points (start, get_id, setget_pixel), each called
// over a four-phase req/ack handshake. The server owns a WIDTH x HEIGHT 8-bit
// frame buffer that the client reads and writes through setget_pixel. start
// clears the buffer to 8'h00, one address per clock.
//
// Optional feature macro: TEST19_CALL_COUNT_EN
//   defined   -> 16-bit count of completed handshakes; get_id returns
//                {SERVER_ID[15:0], count}
//   undefined -> get_id returns SERVER_ID
//
// Ports
//   clk                                 in   1   rising-edge clock
//   reset                               in   1   asynchronous, active-low reset
//   Test19_Server1_start_req            in   1   start call request
//   Test19_Server1_start_ack            out  1   start call acknowledge
//   Test19_Server1_get_id_req           in   1   get_id call request
//   Test19_Server1_get_id_ack           out  1   get_id call acknowledge
//   Test19_Server1_get_id_return        out  32  get_id result
//   Test19_Server1_setget_pixel_req     in   1   pixel call request
//   Test19_Server1_setget_pixel_ack     out  1   pixel call acknowledge
//   Test19_Server1_setget_pixel_x       in   32  column (unsigned)
//   Test19_Server1_setget_pixel_y       in   32  row (unsigned)
//   Test19_Server1_setget_pixel_readf   in   1   1 = read only, 0 = write wdata
//   Test19_Server1_setget_pixel_wdata   in   8   write data
//   Test19_Server1_setget_pixel_return  out  8   previous pixel value
// -----------------------------------------------------------------------------
module test19_server1 #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned HEIGHT    = 16,
    parameter logic [31:0] SERVER_ID = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Test19_Server1_start_req,
    output logic        Test19_Server1_start_ack,
    input  logic        Test19_Server1_get_id_req,
    output logic        Test19_Server1_get_id_ack,
    output logic [31:0] Test19_Server1_get_id_return,
    input  logic        Test19_Server1_setget_pixel_req,
    output logic        Test19_Server1_setget_pixel_ack,
    input  logic [31:0] Test19_Server1_setget_pixel_x,
    input  logic [31:0] Test19_Server1_setget_pixel_y,
    input  logic        Test19_Server1_setget_pixel_readf,
    input  logic [7:0]  Test19_Server1_setget_pixel_wdata,
    output logic [7:0]  Test19_Server1_setget_pixel_return
);

    localparam int unsigned DEPTH  = WIDTH * HEIGHT;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PIX   = 2'd1,
        ST_CLEAR = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Which entry point owns the current handshake.
    typedef enum logic [1:0] {
        CALL_START = 2'd0,
        CALL_PIX   = 2'd1,
        CALL_ID    = 2'd2
    } call_e;

    state_e              state_q, state_d;
    call_e               call_q, call_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic                inr_q, inr_d;

    logic                start_ack_q, start_ack_d;
    logic                id_ack_q, id_ack_d;
    logic [31:0]         id_ret_q, id_ret_d;
    logic                pix_ack_q, pix_ack_d;
    logic [7:0]          pix_ret_q, pix_ret_d;

    // Frame buffer and its registered read port.
    logic [7:0]          mem [DEPTH];
    logic [7:0]          rd_q;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [7:0]          mem_wdata;
    logic                mem_re;

    // Request decode and arbitration: start > setget_pixel > get_id.
    logic                start_sel, pix_sel, id_sel;
    logic                pix_in_range;
    logic [ADDR_W-1:0]   pix_addr;
    logic                clr_last;
    logic                active_req;
    logic                handshake_done;
    logic [31:0]         id_value;

    assign start_sel = Test19_Server1_start_req;
    assign pix_sel   = !Test19_Server1_start_req && Test19_Server1_setget_pixel_req;
    assign id_sel    = !Test19_Server1_start_req && !Test19_Server1_setget_pixel_req
                       && Test19_Server1_get_id_req;

    assign pix_in_range = (Test19_Server1_setget_pixel_x < WIDTH)
                       && (Test19_Server1_setget_pixel_y < HEIGHT);
    // Only meaningful when in range; the truncated value is harmless otherwise
    // because out-of-range accesses never write and return 8'h00.
    assign pix_addr = ADDR_W'(Test19_Server1_setget_pixel_y * WIDTH
                              + Test19_Server1_setget_pixel_x);

    assign clr_last = (clr_addr_q == ADDR_W'(DEPTH - 1));

    always_comb begin
        active_req = 1'b0;
        unique case (call_q)
            CALL_START: active_req = Test19_Server1_start_req;
            CALL_PIX:   active_req = Test19_Server1_setget_pixel_req;
            CALL_ID:    active_req = Test19_Server1_get_id_req;
            default:    active_req = 1'b0;
        endcase
    end

    // The handshake completes on the edge that samples the owning req low.
    assign handshake_done = (state_q == ST_HOLD) && !active_req;

`ifdef TEST19_CALL_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (handshake_done) begin
            cnt_q <= cnt_q + 16'd1;   // wraps 16'hFFFF -> 0 naturally
        end
    end

    assign id_value = {SERVER_ID[15:0], cnt_q};
`else
    assign id_value = SERVER_ID;
`endif

    // -------------------------------------------------------------------------
    // State register (also holds the registered outputs).
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            call_q      <= CALL_START;
            clr_addr_q  <= '0;
            inr_q       <= 1'b0;
            start_ack_q <= 1'b0;
            id_ack_q    <= 1'b0;
            id_ret_q    <= '0;
            pix_ack_q   <= 1'b0;
            pix_ret_q   <= '0;
        end else begin
            state_q     <= state_d;
            call_q      <= call_d;
            clr_addr_q  <= clr_addr_d;
            inr_q       <= inr_d;
            start_ack_q <= start_ack_d;
            id_ack_q    <= id_ack_d;
            id_ret_q    <= id_ret_d;
            pix_ack_q   <= pix_ack_d;
            pix_ret_q   <= pix_ret_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic.
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        call_d     = call_q;
        clr_addr_d = clr_addr_q;
        inr_d      = inr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_sel) begin
                    state_d    = ST_CLEAR;
                    call_d     = CALL_START;
                    clr_addr_d = '0;
                end else if (pix_sel) begin
                    state_d = ST_PIX;
                    call_d  = CALL_PIX;
                    inr_d   = pix_in_range;
                end else if (id_sel) begin
                    state_d = ST_HOLD;
                    call_d  = CALL_ID;
                end
            end
            ST_PIX: begin
                state_d = ST_HOLD;
            end
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_last) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!active_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: next values of the registered acks/returns plus the
    // frame-buffer port controls.
    // -------------------------------------------------------------------------
    always_comb begin
        start_ack_d = start_ack_q;
        id_ack_d    = id_ack_q;
        id_ret_d    = id_ret_q;
        pix_ack_d   = pix_ack_q;
        pix_ret_d   = pix_ret_q;
        mem_we      = 1'b0;
        mem_waddr   = pix_addr;
        mem_wdata   = Test19_Server1_setget_pixel_wdata;
        mem_re      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pix_sel) begin
                    // Read and write share the edge; the read sees the old value.
                    mem_re = 1'b1;
                    mem_we = !Test19_Server1_setget_pixel_readf && pix_in_range;
                end else if (id_sel) begin
                    id_ack_d = 1'b1;
                    id_ret_d = id_value;
                end
            end
            ST_PIX: begin
                pix_ack_d = 1'b1;
                pix_ret_d = inr_q ? rd_q : 8'h00;
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr_q;
                mem_wdata = 8'h00;
                if (clr_last) begin
                    start_ack_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!active_req) begin
                    start_ack_d = 1'b0;
                    id_ack_d    = 1'b0;
                    pix_ack_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the frame buffer has no reset; its contents survive reset and it
    // maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            rd_q <= mem[pix_addr];
        end
    end

    assign Test19_Server1_start_ack           = start_ack_q;
    assign Test19_Server1_get_id_ack          = id_ack_q;
    assign Test19_Server1_get_id_return       = id_ret_q;
    assign Test19_Server1_setget_pixel_ack    = pix_ack_q;
    assign Test19_Server1_setget_pixel_return = pix_ret_q;

endmodule

// File: tb/tb_test19_server1.sv
// -----------------------------------------------------------------------------
// tb_test19_server1
// Self-checking bench for test19_server1. A behavioural model (byte array for
// the frame buffer, a call counter) supplies every expected value.
// -----------------------------------------------------------------------------
module tb_test19_server1;

    logic        clk;
    logic        reset;
    logic        start_req, start_ack;
    logic        id_req, id_ack;
    logic [31:0] id_ret;
    logic        pix_req, pix_ack;
    logic [31:0] pix_x, pix_y;
    logic        pix_readf;
    logic [7:0]  pix_wdata;
    logic [7:0]  pix_ret;

    int          tests = 0;
    int          fails = 0;

    // Reference model.
    logic [7:0]  frame [256];
    int          cnt_model = 0;

    test19_server1 dut (
        .clk                                (clk),
        .reset                              (reset),
        .Test19_Server1_start_req           (start_req),
        .Test19_Server1_start_ack           (start_ack),
        .Test19_Server1_get_id_req          (id_req),
        .Test19_Server1_get_id_ack          (id_ack),
        .Test19_Server1_get_id_return       (id_ret),
        .Test19_Server1_setget_pixel_req    (pix_req),
        .Test19_Server1_setget_pixel_ack    (pix_ack),
        .Test19_Server1_setget_pixel_x      (pix_x),
        .Test19_Server1_setget_pixel_y      (pix_y),
        .Test19_Server1_setget_pixel_readf  (pix_readf),
        .Test19_Server1_setget_pixel_wdata  (pix_wdata),
        .Test19_Server1_setget_pixel_return (pix_ret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_id();
`ifdef TEST19_CALL_COUNT_EN
        return {16'h0013, 16'(cnt_model)};
`else
        return 32'h0000_0013;
`endif
    endfunction

    function automatic logic ack_of(input int kind);
        case (kind)
            0:       return start_ack;
            1:       return pix_ack;
            default: return id_ack;
        endcase
    endfunction

    function automatic logic [31:0] ret_of(input int kind);
        case (kind)
            0:       return 32'h0;
            1:       return {24'h0, pix_ret};
            default: return id_ret;
        endcase
    endfunction

    task automatic set_req(input int kind, input logic v);
        case (kind)
            0:       start_req = v;
            1:       pix_req   = v;
            default: id_req    = v;
        endcase
    endtask

    // One full four-phase call: raise req, wait (bounded) for ack, optionally
    // hold req high while checking stability, drop req and check ack falls.
    task automatic run_call(input int kind, input int hold, input string tag,
                            output int lat, output logic [31:0] ret);
        logic got;
        got = 1'b0;
        lat = 0;
        @(negedge clk);
        set_req(kind, 1'b1);
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            got = ack_of(kind);
        end
        check({tag, "_ack"}, 32'(ack_of(kind)), 32'h1);
        ret = ret_of(kind);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_ack"}, 32'(ack_of(kind)), 32'h1);
            check({tag, "_hold_ret"}, ret_of(kind), ret);
        end
        @(negedge clk);
        set_req(kind, 1'b0);
        @(posedge clk); #1;
        check({tag, "_drop"}, 32'(ack_of(kind)), 32'h0);
        cnt_model++;
    endtask

    task automatic pix_call(input logic [31:0] x, input logic [31:0] y, input logic readf,
                            input logic [7:0] wdata, input int hold, input string tag);
        logic [7:0]  exp;
        logic [31:0] ret;
        int          lat;
        int          idx;
        bit          inr;
        inr = (x < 16) && (y < 16);
        idx = int'(y) * 16 + int'(x);
        exp = inr ? frame[idx] : 8'h00;
        pix_x = x; pix_y = y; pix_readf = readf; pix_wdata = wdata;
        run_call(1, hold, tag, lat, ret);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_ret"}, ret, {24'h0, exp});
        if (inr && !readf) frame[idx] = wdata;
    endtask

    initial begin
        int          lat;
        logic [31:0] ret;
        bit          got;

        reset = 1'b0;
        start_req = 1'b0; id_req = 1'b0; pix_req = 1'b0;
        pix_x = '0; pix_y = '0; pix_readf = 1'b1; pix_wdata = '0;
        for (int i = 0; i < 256; i++) frame[i] = 8'h00;

        // Reset low for two clocks.
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_ack", 32'(start_ack), 32'h0);
        check("rst_id_ack", 32'(id_ack), 32'h0);
        check("rst_pix_ack", 32'(pix_ack), 32'h0);
        check("rst_id_ret", id_ret, 32'h0);
        check("rst_pix_ret", {24'h0, pix_ret}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // No ack while every req stays low.
        repeat (5) @(posedge clk);
        #1;
        check("idle_acks", {29'h0, start_ack, id_ack, pix_ack}, 32'h0);

        // start clears the buffer in WIDTH*HEIGHT+1 clocks.
        run_call(0, 0, "start", lat, ret);
        check("start_lat", 32'(lat), 32'd257);
        pix_call(3, 5, 1'b1, 8'h00, 0, "rd35_clr");

        // Write then read back; write returns the old value.
        pix_call(3, 5, 1'b0, 8'hA7, 0, "wr35");
        pix_call(3, 5, 1'b1, 8'h00, 0, "rd35");

        // Out-of-range write: returns 0 and touches nothing (incl. aliased (4,2)).
        pix_call(20, 1, 1'b0, 8'h55, 0, "wr_oor");
        pix_call(4, 1, 1'b1, 8'h00, 0, "rd41");
        pix_call(4, 2, 1'b1, 8'h00, 0, "rd42");
        pix_call(3, 20, 1'b1, 8'h00, 0, "rd_oor");

        // get_id and setget_pixel together: pixel first, get_id after HOLD.
        @(negedge clk);
        pix_x = 3; pix_y = 5; pix_readf = 1'b1;
        pix_req = 1'b1; id_req = 1'b1;
        @(posedge clk); #1;
        check("arb_e1_pix_ack", 32'(pix_ack), 32'h0);
        check("arb_e1_id_ack", 32'(id_ack), 32'h0);
        @(posedge clk); #1;
        check("arb_pix_ack", 32'(pix_ack), 32'h1);
        check("arb_pix_ret", {24'h0, pix_ret}, {24'h0, frame[5*16+3]});
        check("arb_id_wait", 32'(id_ack), 32'h0);
        @(negedge clk);
        pix_req = 1'b0;
        @(posedge clk); #1;
        check("arb_pix_drop", 32'(pix_ack), 32'h0);
        check("arb_id_still0", 32'(id_ack), 32'h0);
        cnt_model++;
        @(posedge clk); #1;
        check("arb_id_ack", 32'(id_ack), 32'h1);
        check("arb_id_ret", id_ret, exp_id());
        @(negedge clk);
        id_req = 1'b0;
        @(posedge clk); #1;
        check("arb_id_drop", 32'(id_ack), 32'h0);
        cnt_model++;

        // get_id with req held 10 clocks after ack.
        ret = exp_id();
        begin
            logic [31:0] r;
            run_call(2, 10, "id_hold", lat, r);
            check("id_hold_lat", 32'(lat), 32'd1);
            check("id_hold_val", r, ret);
        end

        // Randomised pixel traffic, including out-of-range and held reqs.
        for (int i = 0; i < 40; i++) begin
            pix_call($urandom_range(0, 19), $urandom_range(0, 17),
                     1'($urandom_range(0, 1)), 8'($urandom),
                     int'($urandom_range(0, 2)), "rnd");
        end

        // start beats a simultaneous pixel request.
        @(negedge clk);
        pix_x = 3; pix_y = 5; pix_readf = 1'b1;
        start_req = 1'b1; pix_req = 1'b1;
        got = 1'b0; lat = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            got = start_ack;
            if (!got && pix_ack) got = 1'b1;
        end
        check("pri_start_ack", 32'(start_ack), 32'h1);
        check("pri_start_lat", 32'(lat), 32'd257);
        check("pri_pix_wait", 32'(pix_ack), 32'h0);
        @(negedge clk);
        start_req = 1'b0;
        @(posedge clk); #1;
        check("pri_start_drop", 32'(start_ack), 32'h0);
        cnt_model++;
        for (int i = 0; i < 256; i++) frame[i] = 8'h00;
        @(posedge clk); #1;
        check("pri_pix_e1", 32'(pix_ack), 32'h0);
        @(posedge clk); #1;
        check("pri_pix_ack", 32'(pix_ack), 32'h1);
        check("pri_pix_ret", {24'h0, pix_ret}, 32'h0);
        @(negedge clk);
        pix_req = 1'b0;
        @(posedge clk); #1;
        check("pri_pix_drop", 32'(pix_ack), 32'h0);
        cnt_model++;

        // Reset mid-call: ack drops at once, frame buffer survives.
        pix_call(7, 9, 1'b0, 8'h3C, 0, "wr79");
        @(negedge clk);
        id_req = 1'b1;
        @(posedge clk); #1;
        check("mid_id_ack", 32'(id_ack), 32'h1);
        check("mid_id_ret", id_ret, exp_id());
        reset = 1'b0;
        #1;
        check("mid_rst_ack", 32'(id_ack), 32'h0);
        check("mid_rst_ret", id_ret, 32'h0);
        id_req = 1'b0;
        cnt_model = 0;
        @(negedge clk);
        reset = 1'b1;
        pix_call(7, 9, 1'b1, 8'h00, 0, "rd79_after_rst");
        begin
            logic [31:0] r;
            ret = exp_id();
            run_call(2, 0, "id_after_rst", lat, r);
            check("id_after_rst_val", r, ret);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
